// File: rtl/cam_pkg.sv
// Shared constants and types for the camera pixel path: frame geometry
// defaults, tag widths, packed-word bit positions and the FIFO entry layout.
package cam_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam int GRAY_W = 8;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int WORD_W = 16;

  // Where each slice of the gray value lands inside the two output words
  localparam int D1_G7_POS  = 15;
  localparam int D1_G65_POS = 0;
  localparam int D2_G4_POS  = 15;
  localparam int D2_G32_POS = 11;
  localparam int D2_G10_POS = 0;

  typedef struct packed {
    logic [GRAY_W-1:0] gray;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
  } pix_t;

  // Word 1 carries the top three gray bits, everything else zero
  function automatic logic [WORD_W-1:0] pack_word1(input logic [GRAY_W-1:0] g);
    logic [WORD_W-1:0] w;
    w = '0;
    w[D1_G7_POS]        = g[7];
    w[D1_G65_POS +: 2]  = g[6:5];
    return w;
  endfunction

  // Word 2 carries the low five gray bits split into three fields
  function automatic logic [WORD_W-1:0] pack_word2(input logic [GRAY_W-1:0] g);
    logic [WORD_W-1:0] w;
    w = '0;
    w[D2_G4_POS]        = g[4];
    w[D2_G32_POS +: 2]  = g[3:2];
    w[D2_G10_POS +: 2]  = g[1:0];
    return w;
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO with the head always held in slot0, so the head and its
// valid flag come straight from flops and can drive outputs directly.
module pix_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic         full
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         v0;
  logic         v1;
  logic         do_push;
  logic         do_pop;

  assign do_push    = push && !v1;
  assign do_pop     = pop && v0;
  assign head       = slot0;
  assign head_valid = v0;
  assign full       = v1;

  // Shift slot1 forward on a pop; a push with one entry and a pop lands
  // directly in slot0 so occupancy stays at one and order is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else if (do_pop) begin
      if (v1) begin
        slot0 <= slot1;
        v1    <= 1'b0;
      end else if (do_push) begin
        slot0 <= din;
      end else begin
        v0 <= 1'b0;
      end
    end else if (do_push) begin
      if (!v0) begin
        slot0 <= din;
        v0    <= 1'b1;
      end else begin
        slot1 <= din;
        v1    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_pair_packer.sv
// Tags incoming gray pixels with their (x,y) raster position, buffers them
// two deep and presents each one as a pair of bit-scattered 16-bit words.
// Also flags frame-sync errors and pulses after the last pixel of a frame.
module gray_pair_packer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [GRAY_W-1:0] iGray,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iSOF,
  output logic [WORD_W-1:0] oData1,
  output logic [WORD_W-1:0] oData2,
  output logic              oValid,
  input  logic              iReady,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic              oFrameDone,
  output logic              oSyncErr,
  input  logic              iClrErr
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic                    ready_en;
  logic [X_W-1:0]          x_cnt;
  logic [Y_W-1:0]          y_cnt;
  logic [X_W-1:0]          tag_x;
  logic [Y_W-1:0]          tag_y;
  logic [X_W-1:0]          next_x;
  logic [Y_W-1:0]          next_y;
  logic                    sync_bad;
  logic                    accept;
  logic                    transfer;
  logic                    full;
  logic                    head_valid;
  logic [$bits(pix_t)-1:0] head_bits;
  pix_t                    head_pix;
  pix_t                    wr_pix;
  logic                    frame_done;
  logic                    sync_err;

  assign oReady   = ready_en && !full;
  assign accept   = iValid && oReady;
  assign transfer = head_valid && iReady;

  // Start-of-frame forces the tag to the origin; the counter then advances
  // from the tag, so a resynchronised frame continues at (1,0).
  always_comb begin
    tag_x    = iSOF ? '0 : x_cnt;
    tag_y    = iSOF ? '0 : y_cnt;
    next_x   = tag_x + X_W'(1);
    next_y   = tag_y;
    if (tag_x == X_LAST) begin
      next_x = '0;
      next_y = (tag_y == Y_LAST) ? '0 : tag_y + Y_W'(1);
    end
    sync_bad = iSOF ? ((x_cnt != '0) || (y_cnt != '0))
                    : ((x_cnt == '0) && (y_cnt == '0));
  end

  assign wr_pix = '{gray: iGray, x: tag_x, y: tag_y};

  pix_fifo2 #(
    .W($bits(pix_t))
  ) u_fifo (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .push       (accept),
    .din        (wr_pix),
    .pop        (transfer),
    .head       (head_bits),
    .head_valid (head_valid),
    .full       (full)
  );

  assign head_pix = pix_t'(head_bits);

  // Outputs are plain wiring from the FIFO head flops, so they stay frozen
  // whenever the head is not popped.
  assign oValid     = head_valid;
  assign oData1     = pack_word1(head_pix.gray);
  assign oData2     = pack_word2(head_pix.gray);
  assign oX         = head_pix.x;
  assign oY         = head_pix.y;
  assign oFrameDone = frame_done;
  assign oSyncErr   = sync_err;

  // Input-side raster counters, plus a one-cycle hold-off on ready after reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ready_en <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        x_cnt <= next_x;
        y_cnt <= next_y;
      end
    end
  end

  // Frame-done pulse after the last pixel leaves, and sticky sync error
  // where a new error takes priority over a clear in the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= transfer && (head_pix.x == X_LAST) && (head_pix.y == Y_LAST);
      if (accept && sync_bad) begin
        sync_err <= 1'b1;
      end else if (iClrErr) begin
        sync_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_pair_packer.sv
// Directed bench for gray_pair_packer on a 4x2 frame: packing, back-pressure,
// raster wrap with frame-done, sync errors and reset while data is buffered.
module tb_gray_pair_packer;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [7:0]  iGray = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic        iSOF = 1'b0;
  logic [15:0] oData1;
  logic [15:0] oData2;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic        oFrameDone;
  logic        oSyncErr;
  logic        iClrErr = 1'b0;

  int assert_count = 0;
  int fail_count = 0;

  gray_pair_packer #(
    .H_ACTIVE(4),
    .V_ACTIVE(2)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iGray      (iGray),
    .iValid     (iValid),
    .oReady     (oReady),
    .iSOF       (iSOF),
    .oData1     (oData1),
    .oData2     (oData2),
    .oValid     (oValid),
    .iReady     (iReady),
    .oX         (oX),
    .oY         (oY),
    .oFrameDone (oFrameDone),
    .oSyncErr   (oSyncErr),
    .iClrErr    (iClrErr)
  );

  always #5 iCLK = ~iCLK;

  task automatic applyStimulus(input logic [7:0] g, input logic v, input logic s,
                               input logic r, input logic c);
    iGray   = g;
    iValid  = v;
    iSOF    = s;
    iReady  = r;
    iClrErr = c;
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // reset state
    #3;
    checkOutput("rst_ready", 32'(oReady), 32'd0);
    checkOutput("rst_valid", 32'(oValid), 32'd0);
    checkOutput("rst_data1", 32'(oData1), 32'h0);
    checkOutput("rst_data2", 32'(oData2), 32'h0);
    checkOutput("rst_x", 32'(oX), 32'd0);
    checkOutput("rst_y", 32'(oY), 32'd0);
    checkOutput("rst_done", 32'(oFrameDone), 32'd0);
    checkOutput("rst_err", 32'(oSyncErr), 32'd0);
    #9;
    iRST_N = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_ready", 32'(oReady), 32'd1);
    checkOutput("post_rst_valid", 32'(oValid), 32'd0);

    // packing, one-cycle latency
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pack_valid", 32'(oValid), 32'd1);
    checkOutput("pack_data1", 32'(oData1), 32'h8001);
    checkOutput("pack_data2", 32'(oData2), 32'h0801);
    checkOutput("pack_x", 32'(oX), 32'd0);
    checkOutput("pack_y", 32'(oY), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pack_drained", 32'(oValid), 32'd0);
    checkOutput("pack_err", 32'(oSyncErr), 32'd0);

    // back-pressure: three pixels offered, two accepted, then drain in order
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ready1", 32'(oReady), 32'd1);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ready2", 32'(oReady), 32'd0);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("full_hold_ready", 32'(oReady), 32'd0);
    checkOutput("full_hold_valid", 32'(oValid), 32'd1);
    checkOutput("full_hold_x", 32'(oX), 32'd1);
    checkOutput("full_hold_data1", 32'(oData1), 32'h0000);
    checkOutput("full_hold_data2", 32'(oData2), 32'h8001);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("drain2_x", 32'(oX), 32'd2);
    checkOutput("drain2_data1", 32'(oData1), 32'h0001);
    checkOutput("drain2_data2", 32'(oData2), 32'h0002);
    checkOutput("drain2_ready", 32'(oReady), 32'd1);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("drain3_x", 32'(oX), 32'd3);
    checkOutput("drain3_y", 32'(oY), 32'd0);
    checkOutput("drain3_data2", 32'(oData2), 32'h8003);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(oValid), 32'd0);

    // reset with two pixels buffered
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("buf2_valid", 32'(oValid), 32'd1);
    checkOutput("buf2_ready", 32'(oReady), 32'd0);
    checkOutput("buf2_y", 32'(oY), 32'd1);
    checkOutput("buf2_data1", 32'(oData1), 32'h0002);
    iValid = 1'b0;
    #1;
    iRST_N = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(oValid), 32'd0);
    checkOutput("midrst_ready", 32'(oReady), 32'd0);
    checkOutput("midrst_y", 32'(oY), 32'd0);
    checkOutput("midrst_data1", 32'(oData1), 32'h0000);
    #3;
    iRST_N = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("midrst_rel_ready", 32'(oReady), 32'd1);
    checkOutput("midrst_rel_valid", 32'(oValid), 32'd0);

    // continuous stream across a full 4x2 frame
    applyStimulus(8'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("stream0_x", 32'(oX), 32'd0);
    checkOutput("stream0_y", 32'(oY), 32'd0);
    checkOutput("stream0_valid", 32'(oValid), 32'd1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("stream_x", 32'(oX), 32'(i % 4));
      checkOutput("stream_y", 32'(oY), 32'(i / 4));
      checkOutput("stream_ready", 32'(oReady), 32'd1);
      checkOutput("stream_valid", 32'(oValid), 32'd1);
      checkOutput("stream_done", 32'(oFrameDone), 32'd0);
    end
    checkOutput("stream7_data2", 32'(oData2), 32'h8803);
    applyStimulus(8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("frame_done_pulse", 32'(oFrameDone), 32'd1);
    checkOutput("wrap_x", 32'(oX), 32'd0);
    checkOutput("wrap_y", 32'(oY), 32'd0);
    checkOutput("wrap_err", 32'(oSyncErr), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("frame_done_once", 32'(oFrameDone), 32'd0);
    checkOutput("wrap_empty", 32'(oValid), 32'd0);

    // early start-of-frame on the third pixel of a frame
    applyStimulus(8'h66, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("sync_p2_x", 32'(oX), 32'd1);
    checkOutput("sync_p2_err", 32'(oSyncErr), 32'd0);
    applyStimulus(8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("sync_p3_err", 32'(oSyncErr), 32'd1);
    checkOutput("sync_p3_x", 32'(oX), 32'd0);
    checkOutput("sync_p3_y", 32'(oY), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sync_sticky", 32'(oSyncErr), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("sync_cleared", 32'(oSyncErr), 32'd0);
    applyStimulus(8'h88, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("sync_set_wins", 32'(oSyncErr), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("sync_cleared2", 32'(oSyncErr), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
